// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler
// Sequences one AES encryption job. It selects the key size (nk/nr) and runs
// key expansion unless a still-valid key of the same length is cached. It then
// feeds job_nblk plaintext blocks to the encrypt core, one block in flight at
// a time. Each ciphertext goes back to the host through a valid/ready
// handshake. Timeouts on the key-expansion and core waits latch a sticky err.
// Only abort or reset clears err.
module aes_job_scheduler #(
  parameter int CNT_W      = 8,
  parameter int KE_TIMEOUT = 1023,
  parameter int CORE_TMO   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [1:0]       job_klen,
  input  logic             job_newkey,
  input  logic [CNT_W-1:0] job_nblk,
  input  logic             abort,
  output logic [3:0]       nk,
  output logic [3:0]       nr,
  output logic             ke_start,
  input  logic             ke_done,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             core_load,
  input  logic             core_full,
  input  logic             core_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             job_done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_WAITKE,
    S_ISSUE,
    S_WAITCORE,
    S_RESULT,
    S_ERROR
  } state_t;

  // One shared wait timer serves both timeouts. The two waits never overlap.
  localparam int TMAX = (KE_TIMEOUT > CORE_TMO) ? KE_TIMEOUT : CORE_TMO;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] KE_LIM   = TW'(KE_TIMEOUT);
  localparam logic [TW-1:0] CORE_LIM = TW'(CORE_TMO);

  state_t           state;
  logic [1:0]       klen_q;
  logic [1:0]       last_klen;
  logic             key_ok;
  logic [CNT_W-1:0] nblk_q;
  logic [TW-1:0]    tmr;
  logic [TW-1:0]    tmr_inc;

  // Saturating increment. The >= compare on tmr_inc means a limit of 1 trips
  // after a single waiting cycle.
  assign tmr_inc = (&tmr) ? tmr : tmr + 1'b1;

  // The scheduler takes a job only while idle. This is a pure decode of the
  // state flop.
  assign job_ready = (state == S_IDLE);

  // NOTE: core_load is decoded from the current state and the live block
  // handshake, not registered. That way it coincides with the blk_valid it
  // consumes, and it can only ever be high while the FSM sits in ISSUE.
  assign core_load = (state == S_ISSUE) && !abort && (blk_cnt != nblk_q) &&
                     blk_valid && !core_full;
  assign blk_ready = core_load;

  // Main sequencer: state, job context, timers and registered outputs.
  // NOTE: every register here uses non-blocking assignment, so all of them
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      klen_q    <= 2'b00;
      last_klen <= 2'b00;
      key_ok    <= 1'b0;
      nblk_q    <= '0;
      tmr       <= '0;
      nk        <= 4'd4;
      nr        <= 4'd10;
      ke_start  <= 1'b0;
      res_valid <= 1'b0;
      blk_cnt   <= '0;
      job_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      ke_start <= 1'b0;
      job_done <= 1'b0;
      if (abort) begin
        // abort wins over everything. blk_cnt is kept for the host to inspect.
        state     <= S_IDLE;
        err       <= 1'b0;
        res_valid <= 1'b0;
        key_ok    <= 1'b0;
        tmr       <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (job_valid) begin
              klen_q  <= job_klen;
              nblk_q  <= job_nblk;
              blk_cnt <= '0;
              if (job_klen == 2'b11) begin
                state  <= S_ERROR;
                err    <= 1'b1;
                key_ok <= 1'b0;
              end else begin
                // 128/192/256-bit keys: nk = 4/6/8 words, nr = 10/12/14 rounds.
                nk <= 4'd4  + {1'b0, job_klen, 1'b0};
                nr <= 4'd10 + {1'b0, job_klen, 1'b0};
                if (key_ok && !job_newkey && (job_klen == last_klen)) begin
                  state <= S_ISSUE;
                end else begin
                  state    <= S_KEYEXP;
                  ke_start <= 1'b1;
                end
              end
            end
          end
          S_KEYEXP: begin
            key_ok <= 1'b0;
            tmr    <= '0;
            state  <= S_WAITKE;
          end
          S_WAITKE: begin
            if (ke_done) begin
              key_ok    <= 1'b1;
              last_klen <= klen_q;
              state     <= S_ISSUE;
            end else if (tmr_inc >= KE_LIM) begin
              state <= S_ERROR;
              err   <= 1'b1;
            end else begin
              tmr <= tmr_inc;
            end
          end
          S_ISSUE: begin
            if (blk_cnt == nblk_q) begin
              job_done <= 1'b1;
              state    <= S_IDLE;
            end else if (core_load) begin
              tmr   <= '0;
              state <= S_WAITCORE;
            end
          end
          S_WAITCORE: begin
            if (core_done) begin
              res_valid <= 1'b1;
              state     <= S_RESULT;
            end else if (tmr_inc >= CORE_LIM) begin
              state <= S_ERROR;
              err   <= 1'b1;
            end else begin
              tmr <= tmr_inc;
            end
          end
          S_RESULT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              blk_cnt   <= blk_cnt + 1'b1;
              state     <= S_ISSUE;
            end
          end
          S_ERROR: begin
            err    <= 1'b1;
            key_ok <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Testbench for aes_job_scheduler. A job-level reference model predicts, for
// each job, the key-expansion decision, nk/nr, the block count and the number
// of handshakes. Bench-side responders model the key expansion unit, the
// encrypt core and the host.
module tb_aes_job_scheduler;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             job_valid, job_ready;
  logic [1:0]       job_klen;
  logic             job_newkey;
  logic [CNT_W-1:0] job_nblk;
  logic             abort;
  logic [3:0]       nk, nr;
  logic             ke_start, ke_done;
  logic             blk_valid, blk_ready, core_load, core_full, core_done;
  logic             res_valid, res_ready;
  logic [CNT_W-1:0] blk_cnt;
  logic             job_done, err;

  always #5 clk = ~clk;

  aes_job_scheduler #(.CNT_W(CNT_W), .KE_TIMEOUT(8), .CORE_TMO(20)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_klen(job_klen), .job_newkey(job_newkey), .job_nblk(job_nblk),
    .abort(abort), .nk(nk), .nr(nr), .ke_start(ke_start), .ke_done(ke_done),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .core_load(core_load),
    .core_full(core_full), .core_done(core_done), .res_valid(res_valid),
    .res_ready(res_ready), .blk_cnt(blk_cnt), .job_done(job_done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Event counters and responder state.
  int n_ke = 0, n_load = 0, n_res = 0, n_done = 0, viol = 0, outstanding = 0;
  int ke_cd = 0, core_cd = 0;
  int ke_dly = 5, core_dly = 12, rr_pct = 80;
  bit ke_en = 1'b1, core_en = 1'b1, rand_mode = 1'b0;

  // Reference key cache: what the scheduler should remember between jobs.
  bit         m_key_ok = 1'b0;
  logic [1:0] m_last   = 2'b00;

  // Observe events at the clock edge and arm the key/core responders.
  always @(posedge clk) begin
    if (rst_n) begin
      if (ke_start) begin
        n_ke++;
        if (ke_en) ke_cd = ke_dly;
      end
      if (core_load) begin
        n_load++;
        if (core_en) core_cd = core_dly;
        if (!blk_valid || core_full || !blk_ready) viol++;
        if (outstanding != 0) viol++;
        outstanding = 1;
      end
      if (res_valid && res_ready) begin
        n_res++;
        outstanding = 0;
      end
      if (job_done) n_done++;
    end
  end

  // Drive responder pulses and, in random mode, block/host traffic.
  always @(negedge clk) begin
    ke_done   = 1'b0;
    core_done = 1'b0;
    if (ke_cd > 0) begin
      ke_cd--;
      if (ke_cd == 0) ke_done = 1'b1;
    end
    if (core_cd > 0) begin
      core_cd--;
      if (core_cd == 0) core_done = 1'b1;
    end
    if (rand_mode) begin
      blk_valid = ($urandom_range(0, 99) < 70);
      core_full = ($urandom_range(0, 99) < 25);
      res_ready = ($urandom_range(0, 99) < rr_pct);
    end
  end

  // Present one job at a negedge; returns at the negedge after acceptance.
  task automatic start_job(input logic [1:0] kl, input bit newkey, input int nb);
    int t = 0;
    while (!job_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("job_ready_before_job", job_ready, 1);
    job_valid  = 1'b1;
    job_klen   = kl;
    job_newkey = newkey;
    job_nblk   = CNT_W'(nb);
    @(negedge clk);
    job_valid  = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort       = 1'b0;
    ke_cd       = 0;
    core_cd     = 0;
    outstanding = 0;
    m_key_ok    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int dn0);
    int t = 0;
    while (n_done == dn0 && !err && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("%s.finished", tag), n_done - dn0, 1);
  endtask

  // Run a complete legal job and compare it against the job-level model.
  task automatic run_job(input string tag, input logic [1:0] kl, input bit newkey, input int nb);
    int ke0 = n_ke, ld0 = n_load, rs0 = n_res, dn0 = n_done;
    bit exp_ke;
    exp_ke = !(m_key_ok && !newkey && (kl == m_last));
    start_job(kl, newkey, nb);
    wait_done(tag, dn0);
    check($sformatf("%s.err", tag), err, 0);
    check($sformatf("%s.ke_starts", tag), n_ke - ke0, exp_ke);
    check($sformatf("%s.loads", tag), n_load - ld0, nb);
    check($sformatf("%s.results", tag), n_res - rs0, nb);
    check($sformatf("%s.blk_cnt", tag), blk_cnt, nb);
    check($sformatf("%s.nk", tag), nk, 4 + 2 * kl);
    check($sformatf("%s.nr", tag), nr, 10 + 2 * kl);
    m_key_ok = 1'b1;
    m_last   = kl;
  endtask

  task automatic illegal_job(input string tag);
    start_job(2'b11, 1'b0, 1);
    check($sformatf("%s.err_set", tag), err, 1);
    check($sformatf("%s.ready_low", tag), job_ready, 0);
    do_abort();
    check($sformatf("%s.err_clr", tag), err, 0);
    check($sformatf("%s.ready_back", tag), job_ready, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld0, rs0, dn0, t;
    rst_n = 1'b0; job_valid = 1'b0; job_klen = 2'b00; job_newkey = 1'b0;
    job_nblk = '0; abort = 1'b0; ke_done = 1'b0; blk_valid = 1'b0;
    core_full = 1'b0; core_done = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst.job_ready", job_ready, 1);
    check("rst.nk", nk, 4);
    check("rst.nr", nr, 10);
    check("rst.err", err, 0);
    check("rst.res_valid", res_valid, 0);
    check("rst.blk_cnt", blk_cnt, 0);
    check("rst.ke_start", ke_start, 0);
    check("rst.job_done", job_done, 0);
    check("rst.core_load", core_load, 0);

    // T1/T2: fresh key, cached key, key length change
    blk_valid = 1'b1; core_full = 1'b0; res_ready = 1'b1;
    ke_dly = 5; core_dly = 12;
    run_job("t1", 2'b00, 1'b1, 2);
    run_job("t2a", 2'b00, 1'b0, 2);
    run_job("t2b", 2'b10, 1'b0, 1);

    // T5: zero-block job finishes with job_done on the next-but-one cycle
    ld0 = n_load;
    start_job(2'b10, 1'b0, 0);
    check("t5.done_early", job_done, 0);
    @(negedge clk);
    check("t5.done_pulse", job_done, 1);
    @(negedge clk);
    check("t5.done_once", job_done, 0);
    check("t5.no_load", n_load - ld0, 0);

    // T5: core_full holds off the load
    core_full = 1'b1;
    ld0 = n_load; dn0 = n_done;
    start_job(2'b10, 1'b0, 1);
    repeat (20) @(negedge clk);
    check("full.no_load", n_load - ld0, 0);
    core_full = 1'b0;
    wait_done("full", dn0);
    check("full.load", n_load - ld0, 1);
    check("full.blk_cnt", blk_cnt, 1);

    // T6: host back-pressure holds the result
    res_ready = 1'b0; core_dly = 3;
    dn0 = n_done;
    start_job(2'b10, 1'b0, 1);
    t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check("bp.res_held", res_valid, 1);
    check("bp.cnt_held", blk_cnt, 0);
    res_ready = 1'b1;
    wait_done("bp", dn0);
    check("bp.blk_cnt", blk_cnt, 1);

    // T6: abort on the same cycle as core_done
    core_dly = 4;
    rs0 = n_res;
    start_job(2'b10, 1'b0, 1);
    t = 0;
    while (!core_load && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("abt.loaded", core_load, 1);
    repeat (4) @(negedge clk);
    do_abort();
    check("abt.res_valid", res_valid, 0);
    check("abt.idle", job_ready, 1);
    check("abt.err", err, 0);
    repeat (3) @(negedge clk);
    check("abt.res_still0", res_valid, 0);
    check("abt.no_result", n_res - rs0, 0);

    // T3: illegal key length
    illegal_job("t3");

    // T4: key expansion timeout after 8 waiting cycles
    ke_en = 1'b0;
    start_job(2'b00, 1'b1, 1);
    check("kto.ke_start", ke_start, 1);
    repeat (8) @(negedge clk);
    check("kto.err_before", err, 0);
    @(negedge clk);
    check("kto.err_after", err, 1);
    check("kto.ready_low", job_ready, 0);
    do_abort();
    ke_en = 1'b1;

    // T4: core timeout after 20 waiting cycles
    core_en = 1'b0; ke_dly = 2;
    start_job(2'b00, 1'b1, 1);
    t = 0;
    while (!core_load && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cto.loaded", core_load, 1);
    repeat (20) @(negedge clk);
    check("cto.err_before", err, 0);
    @(negedge clk);
    check("cto.err_after", err, 1);
    do_abort();
    core_en = 1'b1;

    // Randomized jobs against the job-level model
    rand_mode = 1'b1;
    for (int i = 0; i < 14; i++) begin
      int r;
      logic [1:0] kl;
      r        = $urandom_range(0, 9);
      kl       = (r == 9) ? 2'b11 : 2'(r % 3);
      ke_dly   = $urandom_range(1, 7);
      core_dly = $urandom_range(1, 19);
      rr_pct   = $urandom_range(30, 100);
      if (kl == 2'b11) illegal_job($sformatf("rnd%0d", i));
      else run_job($sformatf("rnd%0d", i), kl, ($urandom_range(0, 3) == 0), $urandom_range(0, 5));
    end
    rand_mode = 1'b0;

    check("invariants", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
